// File: rtl/mdio_arbiter.sv
// Two-requester round-robin arbiter in front of a Clause-22 MDIO controller.
// Captures the winning frame, launches it, and reports read data / error on completion.
module mdio_arbiter #(
  parameter int unsigned WR_WAIT    = 128,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        REQ_A,
  input  logic        REQ_B,
  input  logic [31:0] TX_A,
  input  logic [31:0] TX_B,
  output logic        GNT_A,
  output logic        GNT_B,
  output logic        DONE_A,
  output logic        DONE_B,
  output logic [15:0] RD_OUT,
  output logic        ERR,
  output logic        BUSY,
  output logic        MDIO_START,
  output logic [31:0] T_DATA,
  input  logic [15:0] RD_DATA,
  input  logic        DATA_RDY
);

  localparam logic [7:0] WR_LAST = 8'(WR_WAIT - 1);
  localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_WR,
    WAIT_RD,
    DONE
  } state_t;

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [15:0] rd_out_d;
  logic        err_d;
  logic        served_b;
  logic        last_b;
  logic        frame_ok;
  logic        is_rd;

  assign frame_ok = (T_DATA[31:30] == 2'b01) &&
                    ((T_DATA[29:28] == 2'b01) || (T_DATA[29:28] == 2'b10));
  assign is_rd    = (T_DATA[29:28] == 2'b10);

  assign BUSY   = (state != IDLE);
  assign DONE_A = (state == DONE) && !served_b;
  assign DONE_B = (state == DONE) &&  served_b;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rd_out_d   = RD_OUT;
    err_d      = ERR;
    GNT_A      = 1'b0;
    GNT_B      = 1'b0;
    MDIO_START = 1'b0;
    case (state)
      IDLE: begin
        // Grants are Mealy outputs; gate with reset so none appear while held in reset.
        if (rst && REQ_A && (!REQ_B || last_b)) begin
          GNT_A   = 1'b1;
          state_d = START;
        end else if (rst && REQ_B) begin
          GNT_B   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d = '0;
        if (!frame_ok) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          MDIO_START = 1'b1;
          state_d    = is_rd ? WAIT_RD : WAIT_WR;
        end
      end
      WAIT_WR: begin
        cnt_d = cnt + 8'd1;
        if (cnt == WR_LAST) begin
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      WAIT_RD: begin
        cnt_d = cnt + 8'd1;
        if (DATA_RDY) begin
          rd_out_d = RD_DATA;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (cnt == RD_LAST) begin
          rd_out_d = '1;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      RD_OUT   <= '0;
      ERR      <= 1'b0;
      T_DATA   <= '0;
      served_b <= 1'b0;
      last_b   <= 1'b1;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      RD_OUT <= rd_out_d;
      ERR    <= err_d;
      if (GNT_A) begin
        T_DATA   <= TX_A;
        served_b <= 1'b0;
      end else if (GNT_B) begin
        T_DATA   <= TX_B;
        served_b <= 1'b1;
      end
      if (state == DONE) last_b <= served_b;
    end
  end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Randomized self-checking bench for mdio_arbiter against a transaction-level model.
module tb_mdio_arbiter;
  localparam int unsigned WR_WAIT    = 128;
  localparam int unsigned RD_TIMEOUT = 255;

  logic        clk, rst, REQ_A, REQ_B, GNT_A, GNT_B, DONE_A, DONE_B;
  logic        ERR, BUSY, MDIO_START, DATA_RDY;
  logic [31:0] TX_A, TX_B, T_DATA;
  logic [15:0] RD_OUT, RD_DATA;

  mdio_arbiter #(.WR_WAIT(WR_WAIT), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .REQ_A(REQ_A), .REQ_B(REQ_B), .TX_A(TX_A), .TX_B(TX_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .DONE_A(DONE_A), .DONE_B(DONE_B), .RD_OUT(RD_OUT),
    .ERR(ERR), .BUSY(BUSY), .MDIO_START(MDIO_START), .T_DATA(T_DATA),
    .RD_DATA(RD_DATA), .DATA_RDY(DATA_RDY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: who was served last (1 = B) and the held RD_OUT / ERR values.
  bit          m_last_b;
  logic [15:0] m_rd;
  bit          m_err;

  // Observations from the most recent transaction.
  int          ob_gnt_cyc, ob_start_cyc, ob_done_cyc, ob_nstart, ob_ngnt;
  int          ob_tdata_bad, ob_busy_bad;
  bit          ob_timeout;
  logic [1:0]  ob_gnt_vec, ob_done_who;
  logic [31:0] ob_frame;
  logic [15:0] ob_rd;
  logic        ob_err;

  function automatic bit frame_ok(input logic [31:0] f);
    return (f[31:30] == 2'b01) && (f[29:28] == 2'b01 || f[29:28] == 2'b10);
  endfunction

  function automatic bit frame_rd(input logic [31:0] f);
    return f[29:28] == 2'b10;
  endfunction

  // Cycles from grant to DONE according to the protocol rules.
  function automatic int exp_lat(input logic [31:0] f, input int dly);
    if (!frame_ok(f)) return 2;
    if (!frame_rd(f)) return WR_WAIT + 2;
    if (dly >= 1 && dly <= int'(RD_TIMEOUT)) return dly + 2;
    return RD_TIMEOUT + 2;
  endfunction

  function automatic bit exp_winner_b(input bit ra, input bit rb);
    return !(ra && (!rb || m_last_b));
  endfunction

  task automatic model_reset();
    m_last_b = 1'b1;
    m_rd     = 16'h0;
    m_err    = 1'b0;
  endtask

  task automatic model_commit(input logic [31:0] f, input int dly, input logic [15:0] rdata,
                              input bit win_b);
    if (!frame_ok(f)) m_err = 1'b1;
    else if (!frame_rd(f)) m_err = 1'b0;
    else if (dly >= 1 && dly <= int'(RD_TIMEOUT)) begin
      m_rd  = rdata;
      m_err = 1'b0;
    end else begin
      m_rd  = 16'hFFFF;
      m_err = 1'b1;
    end
    m_last_b = win_b;
  endtask

  function automatic logic [31:0] gen_frame(input int kind);
    logic [31:0] f;
    f = $urandom;
    case (kind)
      0: f[31:28] = 4'b0110;
      1: f[31:28] = 4'b0101;
      default: begin
        if ($urandom % 2 == 0) f[31:30] = 2'b00;
        else begin
          f[31:30] = 2'b01;
          f[29:28] = ($urandom % 2 == 0) ? 2'b11 : 2'b00;
        end
      end
    endcase
    return f;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    REQ_A = 1'b0; REQ_B = 1'b0; DATA_RDY = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Drives one transaction and records what the DUT does; inputs change on negedge.
  task automatic do_txn(input bit ra, input bit rb, input logic [31:0] fa, input logic [31:0] fb,
                        input int dly, input logic [15:0] rdata);
    ob_gnt_cyc = -1; ob_start_cyc = -1; ob_done_cyc = -1; ob_nstart = 0; ob_ngnt = 0;
    ob_tdata_bad = 0; ob_busy_bad = 0; ob_timeout = 1'b0; ob_gnt_vec = 2'b00;
    ob_done_who = 2'b00; ob_frame = '0; ob_rd = '0; ob_err = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (n == 0) begin
        REQ_A = ra; REQ_B = rb; TX_A = fa; TX_B = fb;
      end
      if (ob_gnt_cyc >= 0 && n == ob_gnt_cyc + 1) begin
        if (ob_gnt_vec[1]) REQ_B = 1'b0;
        else REQ_A = 1'b0;
      end
      RD_DATA = 16'($urandom);
      if (ob_start_cyc >= 0 && dly > 0 && n == ob_start_cyc + dly) begin
        DATA_RDY = 1'b1;
        RD_DATA  = rdata;
      end else if (ob_start_cyc < 0 || !frame_rd(ob_frame)) DATA_RDY = 1'($urandom % 2);
      else DATA_RDY = 1'b0;
      #1;
      if (GNT_A || GNT_B) begin
        ob_ngnt++;
        if (ob_gnt_cyc < 0) begin
          ob_gnt_cyc = n;
          ob_gnt_vec = {GNT_B, GNT_A};
          ob_frame   = GNT_B ? fb : fa;
        end
      end
      if (MDIO_START) begin
        ob_nstart++;
        if (ob_start_cyc < 0) ob_start_cyc = n;
      end
      if (ob_gnt_cyc >= 0 && n > ob_gnt_cyc) begin
        if (T_DATA !== ob_frame) ob_tdata_bad++;
        if (BUSY !== 1'b1) ob_busy_bad++;
      end
      if (DONE_A || DONE_B) begin
        ob_done_cyc = n;
        ob_done_who = {DONE_B, DONE_A};
        ob_rd       = RD_OUT;
        ob_err      = ERR;
        break;
      end
    end
    if (ob_done_cyc < 0) ob_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; REQ_A = 1'b1; REQ_B = 1'b1; TX_A = 32'h6000_0000; TX_B = 32'h5000_0000;
    DATA_RDY = 1'b1; RD_DATA = 16'h1234;
    @(negedge clk); #1;
    checks++;
    if ({GNT_A, GNT_B, DONE_A, DONE_B, BUSY, MDIO_START, ERR} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {GNT_A, GNT_B, DONE_A, DONE_B, BUSY, MDIO_START, ERR});
    end
    checks++;
    if (T_DATA !== 32'h0) begin
      errors++; $display("FAIL reset_tdata: got %h expected 00000000", T_DATA);
    end
    checks++;
    if (RD_OUT !== 16'h0) begin
      errors++; $display("FAIL reset_rdout: got %h expected 0000", RD_OUT);
    end
    apply_reset();
    #1;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy: got %b expected 0", BUSY);
    end
  endtask

  task automatic test_single_read();
    do_txn(1'b1, 1'b0, 32'h6000_0000, 32'h0, 10, 16'hBEEF);
    model_commit(32'h6000_0000, 10, 16'hBEEF, 1'b0);
    checks++;
    if (ob_timeout || ob_gnt_vec !== 2'b01) begin
      errors++; $display("FAIL read_grant: got %b timeout=%0d expected 01", ob_gnt_vec, ob_timeout);
    end
    checks++;
    if (ob_nstart !== 1 || ob_start_cyc - ob_gnt_cyc !== 1) begin
      errors++;
      $display("FAIL read_start: got count=%0d offset=%0d expected 1/1", ob_nstart,
               ob_start_cyc - ob_gnt_cyc);
    end
    checks++;
    if (ob_done_cyc - ob_start_cyc !== 11 || ob_done_who !== 2'b01) begin
      errors++;
      $display("FAIL read_done: got offset=%0d who=%b expected 11/01",
               ob_done_cyc - ob_start_cyc, ob_done_who);
    end
    checks++;
    if (ob_rd !== 16'hBEEF || ob_err !== 1'b0) begin
      errors++; $display("FAIL read_data: got %h err=%b expected beef err=0", ob_rd, ob_err);
    end
  endtask

  task automatic test_write();
    do_txn(1'b0, 1'b1, 32'h0, 32'h5082_1234, 0, 16'h0);
    model_commit(32'h5082_1234, 0, 16'h0, 1'b1);
    checks++;
    if (ob_timeout || ob_gnt_vec !== 2'b10 || ob_start_cyc - ob_gnt_cyc !== 1) begin
      errors++;
      $display("FAIL write_grant: got %b start_off=%0d expected 10/1", ob_gnt_vec,
               ob_start_cyc - ob_gnt_cyc);
    end
    checks++;
    if (ob_done_cyc - ob_start_cyc !== int'(WR_WAIT) + 1 || ob_done_who !== 2'b10) begin
      errors++;
      $display("FAIL write_done: got offset=%0d who=%b expected %0d/10",
               ob_done_cyc - ob_start_cyc, ob_done_who, WR_WAIT + 1);
    end
    checks++;
    if (ob_err !== 1'b0 || ob_rd !== 16'hBEEF) begin
      errors++; $display("FAIL write_status: got err=%b rd=%h expected 0/beef", ob_err, ob_rd);
    end
    checks++;
    if (ob_tdata_bad !== 0 || ob_busy_bad !== 0 || ob_nstart !== 1) begin
      errors++;
      $display("FAIL write_hold: got tdata_bad=%0d busy_bad=%0d starts=%0d expected 0/0/1",
               ob_tdata_bad, ob_busy_bad, ob_nstart);
    end
  endtask

  task automatic test_tie();
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b1, 1'b1, 32'h6000_0000 | 32'(i), 32'h6080_0000 | 32'(i), 2, 16'(16'h100 + i));
      model_commit(32'h6000_0000, 2, 16'(16'h100 + i), want[i][1]);
      checks++;
      if (ob_timeout || ob_gnt_vec !== want[i] || ob_done_who !== want[i]) begin
        errors++;
        $display("FAIL tie_%0d: got gnt=%b done=%b expected %b", i, ob_gnt_vec, ob_done_who,
                 want[i]);
      end
    end
  endtask

  task automatic test_read_timeout();
    logic [31:0] f;
    f = gen_frame(0);
    do_txn(1'b1, 1'b0, f, 32'h0, 0, 16'h0);
    model_commit(f, 0, 16'h0, 1'b0);
    checks++;
    if (ob_timeout || ob_done_cyc - ob_start_cyc !== int'(RD_TIMEOUT) + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected %0d", ob_done_cyc - ob_start_cyc,
               RD_TIMEOUT + 1);
    end
    checks++;
    if (ob_rd !== 16'hFFFF || ob_err !== 1'b1) begin
      errors++; $display("FAIL timeout_data: got %h err=%b expected ffff err=1", ob_rd, ob_err);
    end
  endtask

  task automatic test_read_boundaries();
    do_txn(1'b0, 1'b1, 32'h0, 32'h6111_0000, int'(RD_TIMEOUT), 16'hA5C3);
    model_commit(32'h6111_0000, int'(RD_TIMEOUT), 16'hA5C3, 1'b1);
    checks++;
    if (ob_done_cyc - ob_start_cyc !== int'(RD_TIMEOUT) + 1 || ob_rd !== 16'hA5C3 ||
        ob_err !== 1'b0) begin
      errors++;
      $display("FAIL rdy_at_timeout: got off=%0d rd=%h err=%b expected %0d/a5c3/0",
               ob_done_cyc - ob_start_cyc, ob_rd, ob_err, RD_TIMEOUT + 1);
    end
    do_txn(1'b1, 1'b0, 32'h6222_0000, 32'h0, 1, 16'h0F0F);
    model_commit(32'h6222_0000, 1, 16'h0F0F, 1'b0);
    checks++;
    if (ob_done_cyc - ob_gnt_cyc !== 3 || ob_rd !== 16'h0F0F || ob_err !== 1'b0) begin
      errors++;
      $display("FAIL min_read_latency: got %0d rd=%h err=%b expected 3/0f0f/0",
               ob_done_cyc - ob_gnt_cyc, ob_rd, ob_err);
    end
  endtask

  task automatic test_bad_frame();
    logic [31:0] bad [2];
    bad[0] = 32'h0000_0000; bad[1] = 32'h7000_0000;
    for (int i = 0; i < 2; i++) begin
      do_txn(1'b1, 1'b0, bad[i], 32'h0, 3, 16'h5555);
      model_commit(bad[i], 3, 16'h5555, 1'b0);
      checks++;
      if (ob_timeout || ob_gnt_vec !== 2'b01 || ob_nstart !== 0) begin
        errors++;
        $display("FAIL bad_frame_%0d_grant: got gnt=%b starts=%0d expected 01/0", i,
                 ob_gnt_vec, ob_nstart);
      end
      checks++;
      if (ob_done_cyc - ob_gnt_cyc !== 2 || ob_err !== 1'b1 || ob_rd !== m_rd) begin
        errors++;
        $display("FAIL bad_frame_%0d_done: got off=%0d err=%b rd=%h expected 2/1/%h", i,
                 ob_done_cyc - ob_gnt_cyc, ob_err, ob_rd, m_rd);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    bit busy_before;
    bit start_seen;
    @(negedge clk);
    REQ_A = 1'b1; REQ_B = 1'b0; TX_A = 32'h6123_0000; DATA_RDY = 1'b0;
    @(negedge clk);
    REQ_A = 1'b0;
    #1 start_seen = MDIO_START;
    repeat (3) @(negedge clk);
    #1 busy_before = BUSY;
    checks++;
    if (!start_seen || !busy_before) begin
      errors++;
      $display("FAIL midread_setup: got start=%b busy=%b expected 1/1", start_seen, busy_before);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({MDIO_START, BUSY, DONE_A, DONE_B} !== 4'b0 || RD_OUT !== 16'h0 || T_DATA !== 32'h0) begin
      errors++;
      $display("FAIL midread_reset: got ctl=%b rd=%h tdata=%h expected 0000/0000/00000000",
               {MDIO_START, BUSY, DONE_A, DONE_B}, RD_OUT, T_DATA);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_txn(1'b1, 1'b1, 32'h6123_0000, 32'h6200_0000, 4, 16'h7777);
    model_commit(32'h6123_0000, 4, 16'h7777, 1'b0);
    checks++;
    if (ob_timeout || ob_gnt_vec !== 2'b01 || ob_rd !== 16'h7777) begin
      errors++;
      $display("FAIL midread_retry: got gnt=%b rd=%h expected 01/7777", ob_gnt_vec, ob_rd);
    end
  endtask

  task automatic test_random();
    bit ra, rb, wb;
    logic [31:0] fa, fb, fw;
    logic [15:0] rdata;
    int dly, lat;
    for (int i = 0; i < 40; i++) begin
      ra = 1'($urandom % 2);
      rb = 1'($urandom % 2);
      if (!ra && !rb) ra = 1'b1;
      fa = gen_frame(int'($urandom_range(0, 3)) % 3);
      fb = gen_frame(int'($urandom_range(0, 3)) % 3);
      dly = ($urandom % 4 == 0) ? int'($urandom_range(0, RD_TIMEOUT + 2))
                                : int'($urandom_range(1, 20));
      rdata = 16'($urandom);
      wb  = exp_winner_b(ra, rb);
      fw  = wb ? fb : fa;
      lat = exp_lat(fw, dly);
      do_txn(ra, rb, fa, fb, dly, rdata);
      model_commit(fw, dly, rdata, wb);
      checks++;
      if (ob_timeout || ob_gnt_vec !== {wb, !wb} || ob_done_who !== {wb, !wb}) begin
        errors++;
        $display("FAIL rand_%0d_owner: got gnt=%b done=%b expected %b", i, ob_gnt_vec,
                 ob_done_who, {wb, !wb});
      end
      checks++;
      if (ob_done_cyc - ob_gnt_cyc !== lat || ob_nstart !== (frame_ok(fw) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_%0d_timing: got lat=%0d starts=%0d expected %0d/%0d", i,
                 ob_done_cyc - ob_gnt_cyc, ob_nstart, lat, frame_ok(fw) ? 1 : 0);
      end
      checks++;
      if (ob_rd !== m_rd || ob_err !== m_err) begin
        errors++;
        $display("FAIL rand_%0d_result: got rd=%h err=%b expected %h/%b", i, ob_rd, ob_err,
                 m_rd, m_err);
      end
      checks++;
      if (ob_tdata_bad !== 0 || ob_busy_bad !== 0 || ob_ngnt !== 1) begin
        errors++;
        $display("FAIL rand_%0d_hold: got tdata_bad=%0d busy_bad=%0d grants=%0d expected 0/0/1",
                 i, ob_tdata_bad, ob_busy_bad, ob_ngnt);
      end
    end
  endtask

  initial begin
    rst = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; TX_A = '0; TX_B = '0;
    DATA_RDY = 1'b0; RD_DATA = '0;
    model_reset();
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_read_timeout();
    test_read_boundaries();
    test_bad_frame();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 Parameter WR_WAIT, default 128: clk cycles from MDIO_START to write completion.
REQ-002 Parameter RD_TIMEOUT, default 255: clk cycles allowed for DATA_RDY on a read before abort.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 REQ_A, REQ_B  input  1  requester A/B transaction request; held high until its GNT.
REQ-006 TX_A, TX_B  input  32  requester A/B Clause-22 frame; stable while its REQ is high.
REQ-007 GNT_A, GNT_B  output  1  one-cycle pulse: frame captured.
REQ-008 DONE_A, DONE_B  output  1  one-cycle pulse: transaction finished.
REQ-009 RD_OUT  output  16  read data; valid in the DONE_x cycle.
REQ-010 ERR  output  1  error flag; valid only in the DONE_x cycle.
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 MDIO_START  output  1  one-cycle start pulse to the MDIO controller.
REQ-013 T_DATA  output  32  frame to the MDIO controller; registered.
REQ-014 RD_DATA  input  16  read data from the MDIO controller.
REQ-015 DATA_RDY  input  1  read-data-valid strobe from the MDIO controller.

Function
REQ-016 The FSM SHALL have states IDLE, START, WAIT_WR, WAIT_RD and DONE.
REQ-017 Frame decode SHALL be: [31:30] ST, [29:28] OP (01 write, 10 read), [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] data.
REQ-018 In IDLE with any REQ high, the FSM SHALL, in that cycle:
- pulse the winner's GNT;
- register its frame into T_DATA;
- go to START.
REQ-019 Arbitration SHALL be round-robin:
- if both REQ are high, the requester not served last wins;
- after reset, A wins the first tie.
REQ-020 A frame with ST!=01 or OP in {00,11} SHALL be granted, then go to DONE with ERR=1, with no MDIO_START issued.
REQ-021 START SHALL last one cycle with MDIO_START=1, then go to WAIT_RD if OP=10, else WAIT_WR.
REQ-022 T_DATA SHALL remain stable from the grant until return to IDLE.
REQ-023 An 8-bit wait counter SHALL clear on entry to WAIT_WR/WAIT_RD and increment each cycle in those states.
REQ-024 WAIT_WR SHALL go to DONE when the counter equals WR_WAIT-1, with ERR=0; DATA_RDY SHALL be ignored in this state.
REQ-025 WAIT_RD behaviour:
- DATA_RDY sampled high: capture RD_DATA into RD_OUT, go to DONE with ERR=0;
- otherwise, counter equals RD_TIMEOUT-1: load RD_OUT=16'hFFFF, go to DONE with ERR=1;
- DATA_RDY wins if both occur in the same cycle.
REQ-026 DONE SHALL last one cycle, pulse the served requester's DONE_x, record it as last-served, and return to IDLE.
REQ-027 The earliest new grant SHALL be the cycle after DONE; minimum read latency from GNT to DONE is 3 cycles.
REQ-028 DATA_RDY in IDLE, START or DONE SHALL be ignored.
REQ-029 REQ changes while BUSY SHALL not affect the transaction in progress.
REQ-030 RD_OUT and ERR SHALL hold their values between DONE cycles.

Reset
REQ-031 While rst=0, independent of clk:
- state=IDLE, last-served=B;
- MDIO_START, GNT_x, DONE_x, BUSY, ERR = 0;
- T_DATA = 32'h0, RD_OUT = 16'h0, counter = 0.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no DONE pulse; the aborted requester SHALL re-request after release.

Verification
REQ-033 Single read: REQ_A with TX_A=32'h6_0...(OP=10), DATA_RDY with RD_DATA=16'hBEEF 10 cycles after MDIO_START -> GNT_A, one MDIO_START, then DONE_A with RD_OUT=16'hBEEF, ERR=0.
REQ-034 Write: REQ_B, TX_B=32'h5082_1234 -> MDIO_START one cycle after GNT_B, DONE_B exactly WR_WAIT+1 cycles after MDIO_START, ERR=0, T_DATA held at 32'h5082_1234 throughout.
REQ-035 Tie: REQ_A and REQ_B high together, twice in a row -> grants A then B, then A when tied again.
REQ-036 Read timeout: read frame, DATA_RDY never asserted -> DONE_x after RD_TIMEOUT cycles in WAIT_RD, RD_OUT=16'hFFFF, ERR=1.
REQ-037 Bad frame: TX_A=32'h0000_0000 -> GNT_A, no MDIO_START, DONE_A with ERR=1 two cycles after GNT_A.
REQ-038 Reset mid-read: rst=0 in WAIT_RD -> MDIO_START, BUSY and DONE_x immediately 0; after release, state IDLE with A winning the next tie.
